// File: rtl/hub_pkg.sv
// Shared constants and types for the nonce uplink hub.
// Defining NONCE_TAG_EN prefixes every frame with the source slave index byte.
package hub_pkg;

  localparam int NONCE_W = 32;
  localparam int BYTE_W  = 8;
`ifdef NONCE_TAG_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam int FRAME_W = FRAME_LEN * BYTE_W;
  localparam int CNT_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Slave index width; a single slave still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + off) mod n, for base < n and off <= n.
  function automatic int wrap_inc(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/nonce_uplink_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_pick
  import hub_pkg::*;
#(
  parameter int SLAVES = 2,
  parameter int IDX_W  = idx_width(SLAVES)
) (
  input  logic [SLAVES-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [2*SLAVES-1:0] dbl_s;
  logic [SLAVES-1:0]   rot_s;

  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit wins.
  assign dbl_s = {req, req} >> rr_ptr;
  assign rot_s = dbl_s[SLAVES-1:0];

  // Scan from the far end down so the nearest request overrides.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      grant_valid = grant_valid | rot_s[k];
      grant_idx   = rot_s[k] ? IDX_W'(wrap_inc(int'(rr_ptr), k, SLAVES)) : grant_idx;
    end
  end

endmodule

// File: rtl/nonce_uplink_arbiter.sv
// Buffers one nonce per hashing core and serializes granted nonces LSB-first to the UART TX.
// Build option NONCE_TAG_EN prepends the slave index byte to each frame.
module nonce_uplink_arbiter
  import hub_pkg::*;
#(
  parameter int SLAVES = 2
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic [SLAVES-1:0]         new_nonces,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  output logic                      tx_valid,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [BYTE_W-1:0]         drop_count
);

  localparam int IDX_W = idx_width(SLAVES);

  state_e                           state_r, state_nxt_s;
  logic [SLAVES-1:0][NONCE_W-1:0]   nonce_buf_r;
  logic [SLAVES-1:0]                pending_r, pending_nxt_s, grant_oh_s;
  logic [IDX_W-1:0]                 rr_ptr_r, rr_ptr_nxt_s, grant_idx_s;
  logic                             grant_valid_s, grant_s;
  logic [FRAME_W-1:0]               shift_r, shift_nxt_s;
  logic [CNT_W-1:0]                 byte_cnt_r, byte_cnt_nxt_s;
  logic                             tx_valid_r, busy_r;
  logic [BYTE_W-1:0]                drop_count_r, drop_nxt_s;
  logic [9:0]                       drop_acc_s;

  rr_pick #(.SLAVES(SLAVES), .IDX_W(IDX_W)) u_pick (
    .req         (pending_r),
    .rr_ptr      (rr_ptr_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  assign tx_valid   = tx_valid_r;
  assign tx_data    = shift_r[BYTE_W-1:0];
  assign busy       = busy_r;
  assign drop_count = drop_count_r;

  // Frame FSM: grant in IDLE, shift one byte out per accepted handshake in SEND.
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    byte_cnt_nxt_s = byte_cnt_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    grant_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          grant_s        = 1'b1;
          state_nxt_s    = SEND;
          byte_cnt_nxt_s = '0;
          rr_ptr_nxt_s   = IDX_W'(wrap_inc(int'(grant_idx_s), 1, SLAVES));
`ifdef NONCE_TAG_EN
          shift_nxt_s    = {nonce_buf_r[grant_idx_s], BYTE_W'(grant_idx_s)};
`else
          shift_nxt_s    = nonce_buf_r[grant_idx_s];
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          shift_nxt_s    = shift_r >> BYTE_W;
          byte_cnt_nxt_s = byte_cnt_r + CNT_W'(1);
          if (byte_cnt_r == CNT_W'(FRAME_LEN - 1)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SEND;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Pending flags and drop accounting; a grant on the same edge as an arrival is not a drop.
  always_comb begin
    grant_oh_s    = '0;
    pending_nxt_s = pending_r;
    drop_acc_s    = {2'b00, drop_count_r};
    for (int i = 0; i < SLAVES; i++) begin
      grant_oh_s[i]    = grant_s & (grant_idx_s == IDX_W'(i));
      pending_nxt_s[i] = new_nonces[i] | (pending_r[i] & ~grant_oh_s[i]);
      drop_acc_s       = drop_acc_s + 10'(new_nonces[i] & pending_r[i] & ~grant_oh_s[i]);
    end
    drop_nxt_s = (drop_acc_s > 10'd255) ? 8'd255 : drop_acc_s[7:0];
  end

  // FSM state, shift register and registered handshake outputs.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      byte_cnt_r <= '0;
      rr_ptr_r   <= '0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shift_r    <= shift_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      tx_valid_r <= (state_nxt_s == SEND);
      busy_r     <= (state_nxt_s == SEND);
    end
  end

  // Per-slave nonce capture, pending flags and the saturating drop counter.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      nonce_buf_r  <= '0;
      pending_r    <= '0;
      drop_count_r <= '0;
    end else begin
      pending_r    <= pending_nxt_s;
      drop_count_r <= drop_nxt_s;
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          nonce_buf_r[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
        end else begin
          nonce_buf_r[i] <= nonce_buf_r[i];
        end
      end
    end
  end

endmodule

// File: doc/nonce_uplink_arbiter.md
# nonce_uplink_arbiter

- Shares the single serial uplink transmitter between `SLAVES` hashing cores.
- Captures each core's nonce on its pulse, buffers one nonce per core and grants cores round-robin.
- Serializes the granted 32-bit nonce into bytes over a valid/ready handshake to the UART transmitter.
- Sits between the slave nonce bus and the UART TX; counts nonces lost to overwrite.

## Interface
- `SLAVES`, default 2 — number of nonce sources, 1..256.
- `hash_clk`  in  1 — single clock; all logic on its rising edge.
- `reset`  in  1 — asynchronous, active-high; clears all state immediately.
- `new_nonces`  in  SLAVES — per-slave one-cycle pulse; nonce valid on `slave_nonces` that cycle.
- `slave_nonces`  in  SLAVES*32 — slave i nonce at bits [32i+31:32i].
- `tx_valid`  out  1 — byte on `tx_data` is valid; reset 0.
- `tx_data`  out  8 — byte to transmit; reset 0.
- `tx_ready`  in  1 — UART accepts the byte when `tx_valid && tx_ready` at a clock edge.
- `busy`  out  1 — a frame is in progress (state SEND); reset 0.
- `drop_count`  out  8 — saturating count of overwritten nonces; reset 0.

## Operation
- Per slave: `nonce_buf[i]` (32 b) and `pending[i]`.
- On `new_nonces[i]`: `nonce_buf[i]` <= nonce, `pending[i]` <= 1.
- If `pending[i]` is already set and slave i is not granted that edge: overwrite with the newer nonce, `drop_count`++ (saturates at 255).
- Grant and arrival on the same slave, same edge: the old value goes to the shift register, the new value is buffered, `pending[i]` stays 1, no drop.
- Round-robin pointer `rr_ptr` (reset 0).
  - Grant the first pending index scanning from `rr_ptr` upward with wrap.
  - On grant, `rr_ptr` <= (grant+1) mod `SLAVES`.
- FSM states:
  - IDLE: if any `pending`, grant: load `shift` <= `nonce_buf[g]`, clear `pending[g]`, byte_cnt <= 0, go to SEND. Otherwise stay.
  - SEND: `tx_valid`=1, `tx_data`=`shift[7:0]`. On `tx_ready`: `shift` >>= 8, byte_cnt++. On acceptance of the last byte (FRAME_LEN-1), go to IDLE.
- Byte order: nonce least-significant byte first.
- `busy` = (state == SEND).
- Nonces are never reordered within one slave.

## Timing
- Pulse sampled at edge t → `pending` set after t → grant at edge t+1 (if IDLE) → `tx_valid` high from after t+1.
- Minimum latency from pulse to first byte valid: 2 edges.
- `tx_valid` and `tx_data` are registered. Once raised, they stay stable until accepted; `tx_valid` never drops mid-frame.
- `tx_ready` held high: one byte per cycle; a FRAME_LEN-byte frame takes FRAME_LEN cycles in SEND.
- Exactly one IDLE cycle between consecutive frames.
- `tx_ready` high while `tx_valid` is low has no effect.
- Reset asserted mid-frame: `tx_valid` and `busy` drop asynchronously. The frame is aborted, all `pending` cleared, `drop_count` and `rr_ptr` zeroed.
- `SLAVES`=1: arbitration degenerates to the single slave; `rr_ptr` stays 0.

## Configuration
- `NONCE_TAG_EN` defined:
  - FRAME_LEN = 5.
  - First byte is the granted slave index, zero-extended to 8 bits, then the 4 nonce bytes.
  - Lets the host identify the source core.
- `NONCE_TAG_EN` undefined:
  - FRAME_LEN = 4, nonce bytes only.
  - No tag logic is synthesized.

## Structure
- Shared package `hub_pkg`:
  - `NONCE_W` = 32.
  - `BYTE_W` = 8.
  - FSM state enum {IDLE, SEND}.
  - `FRAME_LEN` constant, selected by `NONCE_TAG_EN`.
- One sub-module, `rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `grant_valid` and grant index (width `$clog2(SLAVES)`, minimum 1).

## Test plan
- Basic frame:
  - Stimulus: `SLAVES`=2, `tx_ready`=1, pulse slave 0 with 0xDEADBEEF.
  - Response: bytes EF, BE, AD, DE on consecutive cycles; first `tx_valid` 2 edges after the pulse; `busy` falls after DE.
- Round-robin fairness:
  - Stimulus: `SLAVES`=4; simultaneous pulses on all slaves with 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Response: frames in slave order 0, 1, 2, 3. A second burst then starts at slave 0 (`rr_ptr` wrapped).
- Overwrite:
  - Stimulus: hold `tx_ready`=0 during a frame; pulse slave 1 twice with 0xAAAA0001 then 0xAAAA0002.
  - Response: only 0xAAAA0002 is sent for slave 1; `drop_count`=1.
- Backpressure:
  - Stimulus: toggle `tx_ready` randomly through a frame.
  - Response: `tx_data` stable while valid and not ready; byte sequence intact; no duplicate or skipped byte.
- Same-edge grant and arrival:
  - Stimulus: slave 0 pulses 0x00000005 exactly at its grant edge.
  - Response: old nonce sent, then 0x00000005 sent; `drop_count` unchanged.
- Reset mid-frame:
  - Stimulus: assert `reset` after byte 2.
  - Response: `tx_valid` low immediately; after release no residual bytes; `drop_count`=0.
  - Additional run with `NONCE_TAG_EN` defined: slave 3 frame begins with byte 03.
